// File: rtl/command_parse_and_encapsulate_mcnt_pkg.sv
// Shared definitions for the multi-channel counter read/clear register window.
package command_parse_and_encapsulate_mcnt_pkg;

    localparam int OFFSET_W = 19;
    localparam int CLR_BIT  = 0;

    typedef enum logic {
        WORD_LO = 1'b0,
        WORD_HI = 1'b1
    } wordSel_e;

endpackage

// File: rtl/cnt_snapshot_bank.sv
// Per-channel snapshot registers that let a wide counter be read coherently
// as a low word followed by a high word.
module cnt_snapshot_bank
    import command_parse_and_encapsulate_mcnt_pkg::*;
#(
    parameter int NUM_CNT   = 4,
    parameter int CNT_WIDTH = 48,
    parameter int CH_W      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wrEn_i,
    input  logic [CH_W-1:0]      ch_i,
    input  logic [CNT_WIDTH-1:0] wrData_i,
    output logic [31:0]          rdHi_o
);

    logic [CNT_WIDTH-1:0] snap_q [NUM_CNT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                snap_q[k] <= '0;
            end
        end else if (wrEn_i) begin
            snap_q[ch_i] <= wrData_i;
        end
    end

    // Counters of 32 bits or less have no high word, so the shift yields zero.
    assign rdHi_o = 32'(64'(snap_q[ch_i]) >> 32);

endmodule

// File: rtl/command_parse_and_encapsulate_mcnt.sv
// Fixed-address register window exposing NUM_CNT statistics counters with
// registered read returns, coherent wide reads and clear pulses.
module command_parse_and_encapsulate_mcnt
    import command_parse_and_encapsulate_mcnt_pkg::*;
#(
    parameter int              NUM_CNT    = 4,
    parameter int              CNT_WIDTH  = 48,
    parameter logic [18:0]     BASE_ADDR  = 19'h0,
    parameter bit              READ_CLEAR = 1'b0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [18:0]                  iv_addr,
    input  logic                         i_addr_fixed,
    input  logic [31:0]                  iv_wdata,
    input  logic                         i_wr_irx,
    input  logic                         i_rd_irx,
    output logic                         o_wr_irx,
    output logic [18:0]                  ov_addr_irx,
    output logic                         o_addr_fixed_irx,
    output logic [31:0]                  ov_rdata_irx,
    input  logic [NUM_CNT*CNT_WIDTH-1:0] iv_cnt,
    output logic [NUM_CNT-1:0]           ov_cnt_clr
);

    localparam int CH_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
    localparam logic [OFFSET_W-1:0] WINDOW_SIZE = OFFSET_W'(2 * NUM_CNT);

    logic [OFFSET_W-1:0]  offset;
    logic                 hit;
    logic [CH_W-1:0]      ch;
    wordSel_e             wordSel;
    logic                 wrHit;
    logic                 rdHit;
    logic                 rdLoHit;
    logic                 clrCmd;
    logic [CNT_WIDTH-1:0] liveArr [NUM_CNT];
    logic [CNT_WIDTH-1:0] liveCnt;
    logic [31:0]          snapHi;
    logic                 unusedWdata;

    logic                 rspValid_d, rspValid_q;
    logic [18:0]          rspAddr_d, rspAddr_q;
    logic                 rspFixed_d, rspFixed_q;
    logic [31:0]          rspData_d, rspData_q;
    logic [NUM_CNT-1:0]   clr_d, clr_q;

    // Addresses below the base wrap to a huge offset and fall outside the window.
    assign offset  = iv_addr - BASE_ADDR;
    assign hit     = i_addr_fixed && (offset < WINDOW_SIZE);
    assign ch      = offset[CH_W:1];
    assign wordSel = wordSel_e'(offset[0]);

    assign wrHit   = i_wr_irx && hit;
    assign rdHit   = i_rd_irx && !i_wr_irx && hit;
    assign rdLoHit = rdHit && (wordSel == WORD_LO);
    assign clrCmd  = wrHit && (wordSel == WORD_LO) && iv_wdata[CLR_BIT];

    assign unusedWdata = ^iv_wdata[31:1];

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_live
        assign liveArr[k] = iv_cnt[k*CNT_WIDTH +: CNT_WIDTH];
    end
    assign liveCnt = liveArr[ch];

    cnt_snapshot_bank #(
        .NUM_CNT   (NUM_CNT),
        .CNT_WIDTH (CNT_WIDTH),
        .CH_W      (CH_W)
    ) u_snap (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .wrEn_i   (rdLoHit),
        .ch_i     (ch),
        .wrData_i (liveCnt),
        .rdHi_o   (snapHi)
    );

    always_comb begin
        rspValid_d = 1'b0;
        rspAddr_d  = '0;
        rspFixed_d = 1'b0;
        rspData_d  = '0;
        clr_d      = '0;
        if (rdHit) begin
            rspValid_d = 1'b1;
            rspAddr_d  = iv_addr;
            rspFixed_d = i_addr_fixed;
            rspData_d  = (wordSel == WORD_LO) ? 32'(liveCnt) : snapHi;
        end
        if (clrCmd || (READ_CLEAR && rdLoHit)) begin
            clr_d[ch] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rspValid_q <= 1'b0;
            rspAddr_q  <= '0;
            rspFixed_q <= 1'b0;
            rspData_q  <= '0;
            clr_q      <= '0;
        end else begin
            rspValid_q <= rspValid_d;
            rspAddr_q  <= rspAddr_d;
            rspFixed_q <= rspFixed_d;
            rspData_q  <= rspData_d;
            clr_q      <= clr_d;
        end
    end

    assign o_wr_irx         = rspValid_q;
    assign ov_addr_irx      = rspAddr_q;
    assign o_addr_fixed_irx = rspFixed_q;
    assign ov_rdata_irx     = rspData_q;
    assign ov_cnt_clr       = clr_q;

endmodule

// File: tb/tb_command_parse_and_encapsulate_mcnt.sv
// Randomized and directed bench for the counter window; two instances differ
// only in READ_CLEAR and share every input.
module tb_command_parse_and_encapsulate_mcnt;

    localparam int          NUM   = 4;
    localparam int          WID   = 48;
    localparam logic [18:0] BASE  = 19'h40;

    logic             clk = 1'b0;
    logic             rst;
    logic [18:0]      addr;
    logic             fixedSel;
    logic [31:0]      wdata;
    logic             wr;
    logic             rd;
    logic [NUM*WID-1:0] cnt;

    logic             valid0, valid1;
    logic [18:0]      rAddr0, rAddr1;
    logic             rFixed0, rFixed1;
    logic [31:0]      rData0, rData1;
    logic [NUM-1:0]   clr0, clr1;

    int checks = 0;
    int errors = 0;

    // Reference expectations for the cycle after each sampled edge.
    logic             modelReady = 1'b0;
    logic             expValid;
    logic [18:0]      expAddr;
    logic             expFixed;
    logic [31:0]      expData;
    logic [NUM-1:0]   expClr0, expClr1;
    logic [WID-1:0]   snap [NUM];
    logic [18:0]      mOff;
    int               mCh;
    logic [WID-1:0]   mLive;

    always #5 clk = ~clk;

    command_parse_and_encapsulate_mcnt #(
        .NUM_CNT(NUM), .CNT_WIDTH(WID), .BASE_ADDR(BASE), .READ_CLEAR(1'b0)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .iv_addr(addr), .i_addr_fixed(fixedSel),
        .iv_wdata(wdata), .i_wr_irx(wr), .i_rd_irx(rd),
        .o_wr_irx(valid0), .ov_addr_irx(rAddr0), .o_addr_fixed_irx(rFixed0),
        .ov_rdata_irx(rData0), .iv_cnt(cnt), .ov_cnt_clr(clr0)
    );

    command_parse_and_encapsulate_mcnt #(
        .NUM_CNT(NUM), .CNT_WIDTH(WID), .BASE_ADDR(BASE), .READ_CLEAR(1'b1)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .iv_addr(addr), .i_addr_fixed(fixedSel),
        .iv_wdata(wdata), .i_wr_irx(wr), .i_rd_irx(rd),
        .o_wr_irx(valid1), .ov_addr_irx(rAddr1), .o_addr_fixed_irx(rFixed1),
        .ov_rdata_irx(rData1), .iv_cnt(cnt), .ov_cnt_clr(clr1)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one command right after a falling edge, then wait until its response is visible.
    task automatic applyStimulus(input logic r, input logic w, input logic rdS, input logic fx,
                                 input logic [18:0] a, input logic [31:0] d);
        rst = r; wr = w; rd = rdS; fixedSel = fx; addr = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic setCnt(input int ch, input logic [WID-1:0] v);
        cnt[ch*WID +: WID] = v;
    endtask

    // Behavioural model: decode the sampled command by offset arithmetic.
    always @(posedge clk) begin
        expValid = 1'b0; expAddr = '0; expFixed = 1'b0; expData = '0;
        expClr0 = '0; expClr1 = '0;
        if (rst) begin
            for (int k = 0; k < NUM; k++) snap[k] = '0;
        end else begin
            mOff = addr - BASE;
            mCh  = int'(mOff) / 2;
            if (fixedSel && int'(mOff) < 2 * NUM) begin
                if (wr) begin
                    if (mOff[0] == 1'b0 && wdata[0]) begin
                        expClr0 = NUM'(1) << mCh;
                        expClr1 = NUM'(1) << mCh;
                    end
                end else if (rd) begin
                    expValid = 1'b1;
                    expAddr  = addr;
                    expFixed = 1'b1;
                    mLive    = cnt[mCh*WID +: WID];
                    if (mOff[0] == 1'b0) begin
                        expData   = mLive[31:0];
                        snap[mCh] = mLive;
                        expClr1   = NUM'(1) << mCh;
                    end else begin
                        expData = 32'(snap[mCh] >> 32);
                    end
                end
            end
        end
        modelReady = 1'b1;
    end

    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("valid0", 64'(valid0), 64'(expValid));
            checkOutput("valid1", 64'(valid1), 64'(expValid));
            checkOutput("addr0",  64'(rAddr0), 64'(expAddr));
            checkOutput("addr1",  64'(rAddr1), 64'(expAddr));
            checkOutput("fixed0", 64'(rFixed0), 64'(expFixed));
            checkOutput("fixed1", 64'(rFixed1), 64'(expFixed));
            checkOutput("data0",  64'(rData0), 64'(expData));
            checkOutput("data1",  64'(rData1), 64'(expData));
            checkOutput("clr0",   64'(clr0), 64'(expClr0));
            checkOutput("clr1",   64'(clr1), 64'(expClr1));
        end
    end

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; fixedSel = 1'b0; addr = '0; wdata = '0; cnt = '0;
        applyStimulus(1, 0, 0, 0, 19'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 19'h0, 32'h0);
        checkOutput("reset valid", 64'(valid0), 64'h0);
        checkOutput("reset clr",   64'(clr1),   64'h0);
        checkOutput("reset data",  64'(rData0), 64'h0);

        setCnt(2, 48'h1234_89AB_CDEF);
        applyStimulus(0, 0, 1, 1, BASE + 19'd4, 32'h0);
        checkOutput("lo read valid", 64'(valid0), 64'h1);
        checkOutput("lo read data",  64'(rData0), 64'h89AB_CDEF);
        checkOutput("lo read addr",  64'(rAddr0), 64'h44);
        checkOutput("lo read noclr", 64'(clr0),   64'h0);
        checkOutput("lo read rclr",  64'(clr1),   64'h4);

        setCnt(2, 48'hFFFF_0000_0000);
        applyStimulus(0, 0, 1, 1, BASE + 19'd5, 32'h0);
        checkOutput("hi read snap",  64'(rData0), 64'h0000_1234);
        checkOutput("hi read clr",   64'(clr1),   64'h0);

        applyStimulus(0, 1, 0, 1, BASE + 19'd6, 32'h1);
        checkOutput("wr clr pulse",  64'(clr0),   64'h8);
        checkOutput("wr no rsp",     64'(valid0), 64'h0);
        applyStimulus(0, 1, 0, 1, BASE + 19'd6, 32'h0);
        checkOutput("wr data0",      64'(clr0),   64'h0);

        applyStimulus(0, 0, 1, 1, BASE + 19'd8, 32'h0);
        checkOutput("miss offset 8", 64'(valid0), 64'h0);
        applyStimulus(0, 0, 1, 0, BASE, 32'h0);
        checkOutput("miss not fixed", 64'(valid1), 64'h0);
        applyStimulus(0, 0, 1, 1, BASE - 19'd1, 32'h0);
        checkOutput("miss below base", 64'(valid0), 64'h0);

        applyStimulus(0, 1, 1, 1, BASE, 32'h1);
        checkOutput("wr wins clr",   64'(clr0),   64'h1);
        checkOutput("wr wins rsp",   64'(valid0), 64'h0);

        setCnt(1, 48'h5);
        applyStimulus(0, 0, 1, 1, BASE + 19'd2, 32'h0);
        checkOutput("rclr data",     64'(rData1), 64'h5);
        checkOutput("rclr pulse",    64'(clr1),   64'h2);
        applyStimulus(0, 0, 1, 1, BASE + 19'd3, 32'h0);
        checkOutput("rclr hi",       64'(rData1), 64'h0);

        applyStimulus(0, 0, 1, 1, BASE + 19'd0, 32'h0);
        checkOutput("b2b 0", 64'(rAddr0), 64'h40);
        applyStimulus(0, 0, 1, 1, BASE + 19'd2, 32'h0);
        checkOutput("b2b 2", 64'(rAddr0), 64'h42);
        applyStimulus(0, 0, 1, 1, BASE + 19'd4, 32'h0);
        checkOutput("b2b 4", 64'(rAddr0), 64'h44);
        checkOutput("b2b 4 valid", 64'(valid0), 64'h1);

        applyStimulus(0, 0, 1, 1, BASE + 19'd0, 32'h0);
        checkOutput("rst seq first", 64'(valid0), 64'h1);
        applyStimulus(1, 0, 1, 1, BASE + 19'd2, 32'h0);
        checkOutput("rst seq valid", 64'(valid0), 64'h0);
        checkOutput("rst seq addr",  64'(rAddr1), 64'h0);
        checkOutput("rst seq clr",   64'(clr1),   64'h0);
        applyStimulus(0, 0, 1, 1, BASE + 19'd4, 32'h0);
        checkOutput("rst seq third", 64'(rAddr0), 64'h44);

        for (int i = 0; i < 600; i++) begin
            logic [18:0] a;
            if ($urandom_range(0, 3) == 0)
                setCnt(int'($urandom_range(0, NUM - 1)), {16'($urandom), $urandom});
            case ($urandom_range(0, 9))
                0:       a = 19'($urandom);
                1:       a = BASE - 19'($urandom_range(1, 3));
                default: a = BASE + 19'($urandom_range(0, 9));
            endcase
            applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0,
                          a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
